gr8b0nd_fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the multicycle processor's decode/execute.
//  - Issues reads to instruction memory and buffers returned words with their PCs in a prefetch queue.
//  - Presents instructions to decode over a valid/ready handshake.
//  - Accepts PC redirects from branch/jr resolution (bz, bnz, jr) and flushes stale fetches.

---
 rtl/gr8b0nd_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_gr8b0nd_fetch_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gr8b0nd_fetch_unit.sv
// gr8b0nd_fetch_unit: instruction fetch stage with prefetch queue and redirect flush.
// Optional build macro FETCH_STATS_EN adds stat_issued / stat_flushed counters.
module gr8b0nd_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        fetch_hold,
`ifdef FETCH_STATS_EN
    output logic [15:0] stat_issued,
    output logic [15:0] stat_flushed,
`endif
    output logic        fetch_idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   fetch_pc;
    logic [15:0]   req_pc;
    logic [31:0]   q_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          outstanding;
    logic          room;
    logic          can_issue;
    logic          issue;
    logic          push;
    logic          pop;
    logic          discard;

    // Registered counts only: a pop in this cycle does not free a slot yet.
    assign outstanding = (state != FETCH);
    assign room = ({1'b0, count} + {{CW{1'b0}}, outstanding}) < (CW+1)'(DEPTH);
    assign can_issue = reset && !fetch_hold && room;

    assign inst_valid = (count != '0);
    assign inst_pc    = inst_valid ? q_mem[rd_ptr][31:16] : 16'h0;
    assign inst_data  = inst_valid ? q_mem[rd_ptr][15:0] : 16'h0;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;
    assign fetch_idle = (state == FETCH) && (count == '0);

    // Next-state: issue, accept or discard responses; redirect overrides all.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        discard   = 1'b0;
        unique case (state)
            FETCH: begin
                if (!redirect && can_issue) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        discard   = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        push      = 1'b1;
                        issue     = can_issue;
                        state_nxt = can_issue ? WAIT : FETCH;
                    end
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    discard = 1'b1;
                    if (!redirect && can_issue) begin
                        issue     = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    // Fetch PC, issued-PC tag and queue pointers/occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= 16'h0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (redirect)   fetch_pc <= redirect_pc;
            else if (issue) fetch_pc <= fetch_pc + 16'd1;
            if (issue) req_pc <= fetch_pc;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage: {pc, instruction}.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= {req_pc, imem_rdata};
    end

    // The issue rule must never let a response land in a full queue.
    always_ff @(posedge clk) begin
        if (reset && push) assert (count < CW'(DEPTH));
    end

`ifdef FETCH_STATS_EN
    // Issue pulses and flushed work (queued entries plus dropped responses).
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issued  <= 16'h0;
            stat_flushed <= 16'h0;
        end else begin
            if (issue) stat_issued <= stat_issued + 16'd1;
            stat_flushed <= stat_flushed
                          + (redirect ? 16'(count) : 16'h0)
                          + 16'(discard);
        end
    end
`endif

endmodule

// File: tb/tb_gr8b0nd_fetch_unit.sv
// tb_gr8b0nd_fetch_unit: scoreboard bench for the fetch unit.
// Expected {pc, data} pairs are queued by stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_gr8b0nd_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        fetch_hold = 1'b0;
    logic        fetch_idle;

    logic        req2;
    logic [15:0] addr2;
    logic        rv2 = 1'b0;
    logic [15:0] ad2q = 16'h0;
    logic        valid2;
    logic [15:0] data2;
    logic [15:0] pc2;
    logic        idle2;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_flushed;
    logic [15:0] stat_issued2;
    logic [15:0] stat_flushed2;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];
    logic        chk2 = 1'b0;
    logic [31:0] e1;
    logic [31:0] e2;

    int          lat = 1;
    int          lat_cnt = 0;
    logic [15:0] mem_addr_q = 16'h0;

    always #5 clk = ~clk;

    gr8b0nd_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .fetch_hold(fetch_hold),
`ifdef FETCH_STATS_EN
        .stat_issued(stat_issued), .stat_flushed(stat_flushed),
`endif
        .fetch_idle(fetch_idle)
    );

    gr8b0nd_fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rv2), .imem_rdata(ad2q ^ 16'hA5A5),
        .inst_valid(valid2), .inst_data(data2), .inst_pc(pc2),
        .inst_ready(1'b1), .redirect(1'b0),
        .redirect_pc(16'h0), .fetch_hold(1'b0),
`ifdef FETCH_STATS_EN
        .stat_issued(stat_issued2), .stat_flushed(stat_flushed2),
`endif
        .fetch_idle(idle2)
    );

    // Memory with configurable latency for the main instance.
    always @(posedge clk) begin
        if (imem_req) begin
            lat_cnt    <= lat;
            mem_addr_q <= imem_addr;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end
    assign imem_rvalid = (lat_cnt == 1);
    assign imem_rdata  = mem_addr_q ^ 16'hA5A5;

    // One-cycle memory for the wrap-around instance.
    always @(posedge clk) begin
        rv2  <= req2;
        ad2q <= addr2;
    end

    // Monitor: every accepted instruction is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset && inst_valid && inst_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h data=%h", inst_pc, inst_data);
            end else begin
                e1 = exp_q.pop_front();
                if ({inst_pc, inst_data} !== e1) begin
                    errors++;
                    $display("FAIL pop_data: got %h_%h expected %h", inst_pc, inst_data, e1);
                end
            end
        end
    end

    // Monitor for the RESET_PC=FFFE instance.
    always @(negedge clk) begin
        if (reset && chk2 && valid2 && exp2_q.size() > 0) begin
            checks++;
            e2 = exp2_q.pop_front();
            if ({pc2, data2} !== e2) begin
                errors++;
                $display("FAIL wrap_pop: got %h_%h expected %h", pc2, data2, e2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        reset       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        fetch_hold  = 1'b0;
        repeat (5) tick();
        exp_q.delete();
    endtask

    task automatic drain(string name, int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        inst_ready = 1'b0;
        check(name, exp_q.size(), 0);
    endtask

    task automatic push_exp(logic [15:0] pc);
        exp_q.push_back({pc, pc ^ 16'hA5A5});
    endtask

    initial begin
        int nv;
        int nreq;
        int bad;
        logic [15:0] got;
        bit found;

        // Reset state and streaming with 1-cycle memory.
        lat = 1;
        do_reset();
        mid();
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_data", inst_data, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_idle", fetch_idle, 1);
        for (int i = 0; i < 10; i++) push_exp(16'(i));
        exp2_q.push_back({16'hFFFE, 16'hFFFE ^ 16'hA5A5});
        exp2_q.push_back({16'hFFFF, 16'hFFFF ^ 16'hA5A5});
        exp2_q.push_back({16'h0000, 16'h0000 ^ 16'hA5A5});
        exp2_q.push_back({16'h0001, 16'h0001 ^ 16'hA5A5});
        chk2 = 1'b1;
        inst_ready = 1'b1;
        tick();
        reset = 1'b1;
        mid();
        check("t1_c1_req", imem_req, 1);
        check("t1_c1_addr", imem_addr, 16'h0);
        check("t1_c1_valid", inst_valid, 0);
        tick();
        mid();
        check("t1_c2_valid", inst_valid, 0);
        nv = 0;
        for (int c = 3; c <= 12; c++) begin
            tick();
            mid();
            if (inst_valid) nv++;
        end
        check("t1_valid_run", nv, 10);
        tick();
        inst_ready = 1'b0;
        check("t1_sb_empty", exp_q.size(), 0);
        check("t5_wrap_empty", exp2_q.size(), 0);
        chk2 = 1'b0;

        // Back-pressure: queue fills to DEPTH then fetch stops.
        do_reset();
        tick();
        reset = 1'b1;
        nreq = 0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            mid();
            if (imem_req) begin
                if (imem_addr != 16'(nreq)) bad++;
                nreq++;
            end
            tick();
        end
        check("t2_req_count", nreq, 4);
        check("t2_req_addr_bad", bad, 0);
        mid();
        check("t2_valid_held", inst_valid, 1);
        check("t2_head_pc", inst_pc, 16'h0);
        for (int i = 0; i < 6; i++) push_exp(16'(i));
        tick();
        inst_ready = 1'b1;
        got = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            mid();
            if (imem_req) begin
                got = imem_addr;
                break;
            end
            tick();
        end
        check("t2_resume_addr", got, 16'h4);
        drain("t2_drain", 40);

        // Redirect while a 3-cycle request is in flight.
        lat = 3;
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(16'(i));
        push_exp(16'h0100);
        push_exp(16'h0101);
        inst_ready = 1'b1;
        tick();
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (imem_req && imem_addr == 16'h5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t3_issue5", found, 1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        mid();
        check("t3_flushed", inst_valid, 0);
        check("t3_drain_busy", fetch_idle, 0);
        check("t3_drain_noreq", imem_req, 0);
        got = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            mid();
            if (imem_req) begin
                got = imem_addr;
                break;
            end
            tick();
        end
        check("t3_next_addr", got, 16'h0100);
`ifdef FETCH_STATS_EN
        tick();
        check("t3_stat_issued", stat_issued, 16'd7);
        check("t3_stat_flushed", stat_flushed, 16'd2);
`endif
        drain("t3_drain", 60);

        // Redirect in the same cycle as a pop with two entries queued.
        lat = 1;
        do_reset();
        push_exp(16'h0200);
        push_exp(16'h0201);
        tick();
        reset = 1'b1;
        tick();
        tick();
        fetch_hold = 1'b1;
        mid();
        check("t4_hold_noreq", imem_req, 0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        inst_ready  = 1'b1;
        fetch_hold  = 1'b0;
        mid();
        check("t4_two_queued", inst_valid, 1);
        check("t4_head_pc", inst_pc, 16'h0);
        tick();
        redirect = 1'b0;
        mid();
        check("t4_empty_after", inst_valid, 0);
        check("t4_req", imem_req, 1);
        check("t4_addr", imem_addr, 16'h0200);
        drain("t4_drain", 20);

        // fetch_hold with a request outstanding.
        lat = 3;
        do_reset();
        tick();
        reset = 1'b1;
        mid();
        check("t6_req0", imem_req, 1);
        tick();
        fetch_hold = 1'b1;
        nreq = 0;
        for (int c = 0; c < 6; c++) begin
            mid();
            if (imem_req) nreq++;
            tick();
        end
        check("t6_no_req", nreq, 0);
        mid();
        check("t6_valid", inst_valid, 1);
        check("t6_pc", inst_pc, 16'h0);
        check("t6_not_idle", fetch_idle, 0);
        push_exp(16'h0);
        tick();
        inst_ready = 1'b1;
        mid();
        tick();
        inst_ready = 1'b0;
        mid();
        check("t6_idle", fetch_idle, 1);
        check("t6_still_noreq", imem_req, 0);
        check("t6_sb_empty", exp_q.size(), 0);
        fetch_hold = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
